// File: rtl/cover_toggle_pkg.sv
// Shared types and constants for the toggle-coverage scheduler.
// Imported by the interface, the picker and the top level.
package cover_toggle_pkg;

    localparam int COVER_IDX_W         = 64;
    localparam int COVER_TOTAL_DEFAULT = 38253;

    typedef logic [COVER_IDX_W-1:0] cover_idx_t;

endpackage

// File: rtl/cover_toggle_sched_if.sv
// Bundle between a toggle-instrumented block, the scheduler and the coverage port.
// The slave modport is the scheduler's view; master is the producer/consumer side.
interface cover_toggle_sched_if
    import cover_toggle_pkg::*;
#(
    parameter int WIDTH = 42
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] valid;
    logic             clear;
    logic             out_ready;
    logic             out_valid;
    cover_idx_t       out_index;
    logic [CNT_W-1:0] pending_cnt;
    logic [31:0]      report_cnt;
    logic             all_seen;

    modport master (
        output valid, clear, out_ready,
        input  out_valid, out_index, pending_cnt, report_cnt, all_seen
    );

    modport slave (
        input  valid, clear, out_ready,
        output out_valid, out_index, pending_cnt, report_cnt, all_seen
    );

endinterface

// File: rtl/cover_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after start,
// wrapping from WIDTH-1 back to 0.
module cover_rr_pick #(
    parameter  int WIDTH = 42,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    start,
    output logic             found,
    output logic [IW-1:0]    idx
);

    // One extra bit so start + k never overflows before the wrap subtraction.
    logic [IW:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            pos = {1'b0, start} + (IW+1)'(k);
            if (pos >= (IW+1)'(WIDTH)) begin
                pos = pos - (IW+1)'(WIDTH);
            end
            if (!found && req[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cover_toggle_sched.sv
// Round-robin serializer of a toggle hit vector into a cover-index stream.
// Define COVER_TOGGLE_DEDUP_EN to report each point at most once per clear/reset epoch.
module cover_toggle_sched
    import cover_toggle_pkg::*;
#(
    parameter int WIDTH       = 42,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = COVER_TOTAL_DEFAULT
) (
    input  logic                 gbl_clk,
    input  logic                 reset,
    cover_toggle_sched_if.slave  bus
);

    localparam int IW    = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_cfg
        $error("cover_toggle_sched: WIDTH must be >= 2 and COVER_INDEX + WIDTH <= COVER_TOTAL");
    end

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    cover_idx_t       out_index_q, out_index_d;
    logic [31:0]      report_cnt_q, report_cnt_d;
    logic [CNT_W-1:0] pending_cnt_q, pending_cnt_d;

    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             load;
    logic             pick_hit;
    logic [WIDTH-1:0] pick_oh;
    logic [WIDTH-1:0] capture_block;

    cover_rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req   (pending_q),
        .start (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef COVER_TOGGLE_DEDUP_EN
    logic [WIDTH-1:0] seen_q, seen_d;
    logic             all_seen_q, all_seen_d;

    // Points picked this cycle count as seen already, so a same-cycle re-hit is dropped.
    always_comb begin
        capture_block = seen_q | pick_oh;
        seen_d        = bus.clear ? '0 : (seen_q | pick_oh);
        all_seen_d    = &seen_q;
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            seen_q     <= '0;
            all_seen_q <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            all_seen_q <= all_seen_d;
        end
    end

    assign bus.all_seen = all_seen_q;
`else
    logic unused_clear;

    assign unused_clear  = bus.clear;
    assign capture_block = '0;
    assign bus.all_seen  = 1'b0;
`endif

    always_comb begin
        load     = !out_valid_q || bus.out_ready;
        pick_hit = load && pick_found;
        pick_oh  = '0;
        if (pick_hit) begin
            pick_oh[pick_idx] = 1'b1;
        end

        pending_d = (pending_q & ~pick_oh) | (bus.valid & ~capture_block);

        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        if (load) begin
            out_valid_d = pick_found;
        end
        if (pick_hit) begin
            out_index_d = cover_idx_t'(COVER_INDEX) + cover_idx_t'(pick_idx);
            rr_ptr_d    = (pick_idx == IW'(WIDTH - 1)) ? '0 : pick_idx + 1'b1;
        end

        report_cnt_d = report_cnt_q;
        if (out_valid_q && bus.out_ready && report_cnt_q != 32'hFFFF_FFFF) begin
            report_cnt_d = report_cnt_q + 32'd1;
        end

        pending_cnt_d = '0;
        for (int k = 0; k < WIDTH; k++) begin
            pending_cnt_d = pending_cnt_d + CNT_W'(pending_d[k]);
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            report_cnt_q  <= '0;
            pending_cnt_q <= '0;
        end else begin
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            out_valid_q   <= out_valid_d;
            out_index_q   <= out_index_d;
            report_cnt_q  <= report_cnt_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_index   = out_index_q;
    assign bus.report_cnt  = report_cnt_q;
    assign bus.pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed bench for cover_toggle_sched: expected indices are queued when hits are
// driven and popped on each handshake; works with or without COVER_TOGGLE_DEDUP_EN.
module tb_cover_toggle_sched;
    import cover_toggle_pkg::*;

    localparam int W  = 42;
    localparam int CI = 100;
`ifdef COVER_TOGGLE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cover_toggle_sched_if #(.WIDTH(W)) bus ();

    cover_toggle_sched #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .COVER_TOTAL (COVER_TOTAL_DEFAULT)
    ) dut (
        .gbl_clk (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    int              n_cmp = 0;
    int              n_err = 0;
    longint unsigned exp_q[$];
    logic [W-1:0]    v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Inspect the handshake at the falling edge, then advance past the next rising edge.
    task automatic cycle();
        longint unsigned e;
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_report: observed index %0d required no report", bus.out_index);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("report: index=%0d expected=%0d", bus.out_index, e);
                check("report_index", bus.out_index, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycle();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        bus.valid     = '1;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset with all points hit
        repeat (3) cycle();
        check("rst_out_valid",   bus.out_valid, 0);
        check("rst_out_index",   bus.out_index, 0);
        check("rst_pending_cnt", bus.pending_cnt, 0);
        check("rst_report_cnt",  bus.report_cnt, 0);
        check("rst_all_seen",    bus.all_seen, 0);

        // Single hit latency
        rst_n = 1'b1;
        bus.valid = '0;
        cycle();
        v = '0; v[5] = 1'b1;
        bus.valid = v;
        exp_q.push_back(CI + 5);
        cycle();
        bus.valid = '0;
        check("t1_pending_cnt", bus.pending_cnt, 1);
        cycle();
        check("t1_out_valid", bus.out_valid, 1);
        check("t1_out_index", bus.out_index, CI + 5);
        drain("t1_drain");
        check("t1_report_cnt", bus.report_cnt, 1);

        // Park rr_ptr at 40, then simultaneous hits with wrap
        v = '0; v[39] = 1'b1;
        bus.valid = v;
        exp_q.push_back(CI + 39);
        cycle();
        bus.valid = '0;
        drain("t2_pre_drain");
        cycle();
        v = '0; v[0] = 1'b1; v[3] = 1'b1; v[41] = 1'b1;
        bus.valid = v;
        exp_q.push_back(CI + 41);
        exp_q.push_back(CI + 0);
        exp_q.push_back(CI + 3);
        cycle();
        bus.valid = '0;
        check("t2_pcnt3", bus.pending_cnt, 3);
        cycle();
        check("t2_pcnt2", bus.pending_cnt, 2);
        cycle();
        check("t2_pcnt1", bus.pending_cnt, 1);
        cycle();
        check("t2_pcnt0", bus.pending_cnt, 0);
        drain("t2_drain");
        check("t2_report_cnt", bus.report_cnt, 5);

        // Backpressure with three points pending (rr_ptr = 4)
        bus.out_ready = 1'b0;
        v = '0; v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1;
        bus.valid = v;
        exp_q.push_back(CI + 10);
        exp_q.push_back(CI + 20);
        exp_q.push_back(CI + 30);
        cycle();
        bus.valid = '0;
        cycle();
        check("t3_out_valid", bus.out_valid, 1);
        check("t3_out_index", bus.out_index, CI + 10);
        check("t3_pcnt", bus.pending_cnt, 2);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_hold_index", bus.out_index, CI + 10);
            check("t3_hold_report_cnt", bus.report_cnt, 5);
        end
        bus.out_ready = 1'b1;
        drain("t3_drain");
        check("t3_report_cnt", bus.report_cnt, 8);

        // Repeated hits on point 7, then clear and hit again
        v = '0; v[7] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 2 || c == 5 || c == 8) begin
                bus.valid = v;
                if (!DEDUP || c == 0) exp_q.push_back(CI + 7);
            end else begin
                bus.valid = '0;
            end
            cycle();
        end
        bus.valid = '0;
        drain("t4_drain");
        repeat (2) cycle();
        check("t4_report_cnt", bus.report_cnt, DEDUP ? 9 : 12);
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        bus.valid = v;
        exp_q.push_back(CI + 7);
        cycle();
        bus.valid = '0;
        drain("t4_clear_drain");
        repeat (2) cycle();
        check("t4_clear_report_cnt", bus.report_cnt, DEDUP ? 10 : 13);
        check("t4_all_seen", bus.all_seen, 0);

        // All points once (rr_ptr = 8)
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        bus.valid = '1;
        for (int k = 8; k < W; k++) exp_q.push_back(CI + k);
        for (int k = 0; k < 8; k++) exp_q.push_back(CI + k);
        cycle();
        bus.valid = '0;
        check("t5_pcnt", bus.pending_cnt, W);
        for (int k = 0; k < W; k++) begin
            cycle();
            check("t5_all_seen_low", bus.all_seen, 0);
        end
        check("t5_last_index", bus.out_index, CI + 7);
        cycle();
        check("t5_all_seen_final", bus.all_seen, DEDUP ? 1 : 0);
        drain("t5_drain");
        check("t5_report_cnt", bus.report_cnt, DEDUP ? 52 : 55);

        // Mid-stream reset with one report presented and ten pending
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        bus.out_ready = 1'b0;
        v = '0;
        for (int k = 10; k <= 20; k++) v[k] = 1'b1;
        bus.valid = v;
        cycle();
        bus.valid = '0;
        cycle();
        check("t6_pre_out_valid", bus.out_valid, 1);
        check("t6_pre_pcnt", bus.pending_cnt, 10);
        rst_n = 1'b0;
        bus.valid = '1;
        cycle();
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_pcnt", bus.pending_cnt, 0);
        check("t6_report_cnt", bus.report_cnt, 0);
        check("t6_out_index", bus.out_index, 0);
        check("t6_all_seen", bus.all_seen, 0);
        rst_n = 1'b1;
        bus.valid = '0;
        bus.out_ready = 1'b1;
        repeat (6) cycle();
        check("t6_post_out_valid", bus.out_valid, 0);
        check("t6_post_report_cnt", bus.report_cnt, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cover_toggle_sched.md
# cover_toggle_sched

Round-robin scheduler that serializes a wide toggle-coverage hit vector into a single cover-index stream, one index per accepted handshake. It sits between a toggle-instrumented module's `valid` vector and the shared coverage reporting port (the DPI bridge or the formal/fuzz coverage collector). Many coverage points share that one port without dropping hits. Optional first-hit deduplication reports each point at most once until an explicit clear.

## Interface
- `WIDTH`, 42: number of toggle points in the `valid` vector; must be ≥2.
- `COVER_INDEX`, 0: global index of bit 0. Bit i reports `COVER_INDEX + i`.
- `COVER_TOTAL`, 38253: total global cover points; used only by the assertion `COVER_INDEX + WIDTH <= COVER_TOTAL`.
- `gbl_clk` input 1: clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; clock `gbl_clk`.
- `valid` input WIDTH: per-point hit strobes, sampled every cycle.
- `clear` input 1: one-cycle pulse; empties the seen bitmap.
- `out_ready` input 1: consumer accepts `out_index` this cycle.
- `out_valid` output 1: `out_index` holds a report.
- `out_index` output 64: global cover index (`COVER_IDX_W`).
- `pending_cnt` output $clog2(WIDTH+1): popcount of the pending bitmap.
- `report_cnt` output 32: accepted handshakes; saturates at 0xFFFF_FFFF.
- `all_seen` output 1: every point has been reported since the last clear or reset.

## Operation
- State:
  - `pending[WIDTH]`, `seen[WIDTH]`.
  - Output register (`out_valid`, `out_index`).
  - `rr_ptr` of width $clog2(WIDTH).
  - `report_cnt`.
- Capture: on each edge, `pending[i]` is set if `valid[i]` is high, and, with dedup enabled, `seen[i]` is clear. Multiple hits on a point that is already pending collapse into one report.
- Load condition: the output register loads when `!out_valid || out_ready`.
- Pick: search `pending` starting at `rr_ptr` and wrap past WIDTH-1 to 0. The first set bit g is the winner.
- On load with a winner:
  - `out_valid` goes to 1 and `out_index` to `COVER_INDEX + g`.
  - `pending[g]` clears and `seen[g]` sets.
  - `rr_ptr` moves to (g+1) mod WIDTH, so WIDTH-1 wraps to 0.
- On load with no winner: `out_valid` goes to 0; `out_index` holds its last value.
- Handshake: `out_valid && out_ready` at an edge increments `report_cnt`, saturating.
- Same cycle, `valid[g]` and pick of g: the pick consumes g. Without dedup, the new hit re-pends g. With dedup, it is dropped because `seen[g]` is set.
- `clear`:
  - Zeros `seen` and overrides any same-cycle set of `seen`.
  - Leaves `pending`, the output register and `report_cnt` untouched.
- `all_seen` is `&seen` and is registered.
- Reset (`reset` == 0 at an edge, including mid-stream), all state returns to zero:
  - `pending`, `seen`, `rr_ptr`.
  - `out_valid`, `out_index` (64'h0).
  - `report_cnt`, `pending_cnt`, `all_seen`.
  - `valid` is ignored during reset cycles.
- `out_index` is stable while `out_valid && !out_ready`.

## Timing
- Latency: `valid[i]` high at edge N, with nothing else pending and `out_ready` high → `out_valid`/`out_index` present after edge N+1.
- Throughput: one report per cycle while `out_ready` is held high.
- `pending_cnt` reflects the pending bitmap after the current edge (registered popcount).
- `all_seen` rises the cycle after the last `seen` bit sets.

## Configuration
- `COVER_TOGGLE_DEDUP_EN` defined:
  - The `seen` bitmap gates capture.
  - Each point is reported at most once per clear/reset epoch.
- Not defined:
  - `seen` is not built and capture is ungated.
  - A point re-reports whenever it is hit again after being picked.
  - `all_seen` is tied to 0 and `clear` is ignored.

## Structure
- Package `cover_toggle_pkg`:
  - `COVER_IDX_W` = 64.
  - `COVER_TOTAL_DEFAULT` = 38253.
  - Typedef `cover_idx_t` of type logic [63:0].
- Sub-module `cover_rr_pick`:
  - Combinational round-robin finder with parameter WIDTH.
  - Inputs: `req[WIDTH]`, `start`.
  - Outputs: `found`, `idx`.
- Top level holds all registers.

## Test plan
- Reset and single hit: hold reset low for 3 cycles with `valid`=all ones → all outputs 0. Release reset; pulse `valid[5]` at edge N with `COVER_INDEX`=100 → `out_valid`=1, `out_index`=105 after edge N+1; `report_cnt`=1 after the handshake.
- Simultaneous hits and wrap: `valid`=bits {0, 3, 41}, `rr_ptr`=40 → reports 141, 100, 103 on consecutive cycles; `pending_cnt` steps 3→2→1→0.
- Backpressure: `out_ready`=0 for 5 cycles with 3 points pending → `out_index` holds its first value; `report_cnt` is unchanged; the pending points are then drained in RR order once `out_ready`=1.
- Dedup:
  - With the macro, hit `valid[7]` 4 times across 10 cycles → exactly one report of 107. Pulse `clear`, hit `valid[7]` again → a second report of 107.
  - Without the macro → four reports.
- Coverage complete: with dedup, drive all 42 points once → 42 reports, and `all_seen`=1 one cycle after the last pick.
- Mid-stream reset: assert reset while `out_valid`=1 and 10 points are pending → `out_valid`=0, `pending_cnt`=0, `report_cnt`=0 at the next edge, and no stale index emitted afterwards.
